cache_trace_driver: RTL

Trace-side initiator for the multi-level cache model. Buffers a loaded trace of memory references (address, op, target level), then replays them one at a time to the cache engine's request inputs, waiting for completion before issuing the next. It also keeps per-run read/write/issue statistics for cross-checking the engine's counters. It sits between the testbench or trace loader and the cache engine.

---
 rtl/cache_trace_driver.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_trace_driver.sv
// cache_trace_driver: buffers a trace of memory references and replays them
// one at a time to the cache engine, waiting for completion between requests.
// Consecutive duplicate addresses are skipped because the engine ignores them.
module cache_trace_driver #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [47:0] load_addr,
    input  logic [7:0]  load_op,
    input  logic        load_lvl,
    input  logic        start,
    input  logic        req_done,
    output logic [47:0] cache_addr,
    output logic [7:0]  cache_op,
    output logic        cache_lvl,
    output logic        req_valid,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        timeout_err,
    output logic [11:0] issued_count,
    output logic [11:0] read_count,
    output logic [11:0] write_count,
    output logic [11:0] dup_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW = $clog2(DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CW = 12;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  OP_WRITE = 8'h57;

    typedef struct packed {
        logic [47:0] addr;
        logic [7:0]  op;
        logic        lvl;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    entry_t          mem [DEPTH];
    entry_t          entry_q;
    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [NW-1:0]   n_entries;
    logic [TW-1:0]   timer;
    logic [47:0]     last_addr;
    logic            issued_any;
    logic            buf_full;
    logic            load_accept;
    logic            is_last;
    logic            is_dup;

    assign buf_full    = (n_entries == NW'(DEPTH));
    assign load_accept = load_valid && !busy && !buf_full;
    assign is_last     = ({{(NW-AW){1'b0}}, rd_ptr} == (n_entries - NW'(1)));
    assign is_dup      = issued_any && (entry_q.addr == last_addr);

    // Trace storage: written by the loader, read one entry per FETCH
    always_ff @(posedge clk) begin
        if (!reset && load_accept) begin
            mem[wr_ptr] <= '{addr: load_addr, op: load_op, lvl: load_lvl};
        end
    end

    // Load pointer, entry count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            n_entries <= '0;
            overflow  <= 1'b0;
        end else if (load_valid && !busy) begin
            if (buf_full) begin
                overflow <= 1'b1;
            end else begin
                wr_ptr    <= wr_ptr + AW'(1);
                n_entries <= n_entries + NW'(1);
            end
        end
    end

    // Replay sequencer with registered request, status and statistics outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rd_ptr       <= '0;
            entry_q      <= '0;
            timer        <= '0;
            last_addr    <= '0;
            issued_any   <= 1'b0;
            cache_addr   <= '0;
            cache_op     <= '0;
            cache_lvl    <= 1'b0;
            req_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            issued_count <= '0;
            read_count   <= '0;
            write_count  <= '0;
            dup_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        issued_count <= '0;
                        read_count   <= '0;
                        write_count  <= '0;
                        dup_count    <= '0;
                        timeout_err  <= 1'b0;
                        issued_any   <= 1'b0;
                        rd_ptr       <= '0;
                        busy         <= 1'b1;
                        state        <= (n_entries == '0) ? S_FINISH : S_FETCH;
                    end
                end
                S_FETCH: begin
                    entry_q <= mem[rd_ptr];
                    state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (is_dup) begin
                        dup_count <= dup_count + CW'(1);
                        rd_ptr    <= rd_ptr + AW'(1);
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        cache_addr   <= entry_q.addr;
                        cache_op     <= entry_q.op;
                        cache_lvl    <= entry_q.lvl;
                        req_valid    <= 1'b1;
                        issued_count <= issued_count + CW'(1);
                        if (entry_q.op == OP_READ) begin
                            read_count <= read_count + CW'(1);
                        end
                        if (entry_q.op == OP_WRITE) begin
                            write_count <= write_count + CW'(1);
                        end
                        timer <= TW'(TIMEOUT);
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (req_done) begin
                        req_valid  <= 1'b0;
                        last_addr  <= cache_addr;
                        issued_any <= 1'b1;
                        rd_ptr     <= rd_ptr + AW'(1);
                        if (is_last) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else if (state == S_ISSUE) begin
                        state <= S_WAIT;
                    end else if (timer <= TW'(1)) begin
                        // Engine never answered: abort the run
                        timeout_err <= 1'b1;
                        req_valid   <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_FINISH: begin
                    // Entered from IDLE on an empty buffer with done still low
                    if (done) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
